// File: rtl/rle_pkg.sv
// ----------------------------------------------------------------------------
// rle_pkg
// Shared types and constants for the feature-map line run-length encoder.
//   rle_state_e : encoder FSM states
//   ZRUN_MAX    : largest zero-run that fits the Z byte
//   ORUN_MAX    : largest one-run that fits the 7-bit O field
//   ONE_MARK    : marker bit that flags the second byte of a pair
// ----------------------------------------------------------------------------
package rle_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ZERO   = 3'd1,
    ONE    = 3'd2,
    EMIT_Z = 3'd3,
    EMIT_O = 3'd4
  } rle_state_e;

  localparam int unsigned ZC_W = 8;
  localparam int unsigned OC_W = 7;

  localparam logic [ZC_W-1:0] ZRUN_MAX = 8'd255;
  localparam logic [OC_W-1:0] ORUN_MAX = 7'd127;
  localparam logic [7:0]      ONE_MARK = 8'h80;

  // Second byte of a pair: marker bit plus the one-run count.
  function automatic logic [7:0] one_byte(input logic [OC_W-1:0] oc);
    return ONE_MARK | {1'b0, oc};
  endfunction

endpackage : rle_pkg

// File: rtl/rle_compress.sv
// ----------------------------------------------------------------------------
// rle_compress
// Run-length encoder for one binary feature-map line. The line is scanned
// MSB-first, one bit per cycle, and emitted as byte pairs
// (Z = zero-run 0..255, {1, O} = one-run 0..127) for the line decompressor.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; abandons any line in flight
//   in_valid   in_line is valid
//   in_ready   a line can be accepted (IDLE and not in reset)
//   in_line    line to encode, bit LINE_W-1 first
//   out_valid  out_byte is valid (registered)
//   out_ready  downstream accepts out_byte
//   out_byte   encoded byte (registered)
//   out_last   final byte of the line (registered, only with out_valid)
//   busy       line accepted and its last byte not yet taken (registered)
// ----------------------------------------------------------------------------
module rle_compress
  import rle_pkg::*;
#(
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LINE_W-1:0] in_line,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(LINE_W);

  rle_state_e        state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ZC_W-1:0]   zc_q, zc_d;
  logic [OC_W-1:0]   oc_q, oc_d;
  logic              end_q, end_d;

  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_byte_q, out_byte_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;

  logic              cur_bit;
  logic              last_bit;
  logic [ZC_W-1:0]   zc_inc;
  logic [OC_W-1:0]   oc_inc;
  logic [LINE_W-1:0] line_shl;

  // The line is shifted left as bits are consumed, so the bit under
  // examination is always the MSB; idx only tracks how many remain.
  assign cur_bit  = line_q[LINE_W-1];
  assign last_bit = (idx_q == '0);
  assign zc_inc   = zc_q + ZC_W'(1);
  assign oc_inc   = oc_q + OC_W'(1);
  assign line_shl = {line_q[LINE_W-2:0], 1'b0};

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      line_q      <= '0;
      idx_q       <= '0;
      zc_q        <= '0;
      oc_q        <= '0;
      end_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      idx_q       <= idx_d;
      zc_q        <= zc_d;
      oc_q        <= oc_d;
      end_q       <= end_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: scan, count runs, hand pairs out.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    idx_d   = idx_q;
    zc_d    = zc_q;
    oc_d    = oc_q;
    end_d   = end_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          line_d  = in_line;
          idx_d   = IDX_W'(LINE_W - 1);
          zc_d    = '0;
          oc_d    = '0;
          end_d   = 1'b0;
          state_d = ZERO;
        end
      end

      ZERO: begin
        if (!cur_bit) begin
          zc_d   = zc_inc;
          line_d = line_shl;
          // End of line wins over saturation; both leave for EMIT_Z.
          if (last_bit) begin
            end_d   = 1'b1;
            state_d = EMIT_Z;
          end else begin
            idx_d = idx_q - IDX_W'(1);
            if (zc_inc == ZRUN_MAX) begin
              state_d = EMIT_Z;
            end
          end
        end else begin
          // The 1 is left in place for ONE to consume.
          state_d = ONE;
        end
      end

      ONE: begin
        if (cur_bit) begin
          oc_d   = oc_inc;
          line_d = line_shl;
          if (last_bit) begin
            end_d   = 1'b1;
            state_d = EMIT_Z;
          end else begin
            idx_d = idx_q - IDX_W'(1);
            if (oc_inc == ORUN_MAX) begin
              state_d = EMIT_Z;
            end
          end
        end else begin
          state_d = EMIT_Z;
        end
      end

      EMIT_Z: begin
        if (out_ready) begin
          state_d = EMIT_O;
        end
      end

      EMIT_O: begin
        if (out_ready) begin
          zc_d    = '0;
          oc_d    = '0;
          state_d = end_q ? IDLE : ZERO;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output registers are loaded from the next state so out_valid, out_byte
  // and out_last line up with the EMIT states without an extra cycle.
  always_comb begin
    out_valid_d = 1'b0;
    out_byte_d  = '0;
    out_last_d  = 1'b0;
    busy_d      = (state_d != IDLE);

    if (state_d == EMIT_Z) begin
      out_valid_d = 1'b1;
      out_byte_d  = zc_d;
    end else if (state_d == EMIT_O) begin
      out_valid_d = 1'b1;
      out_byte_d  = one_byte(oc_d);
      out_last_d  = end_d;
    end
  end

endmodule : rle_compress
